blob_track_filter: RTL and testbench

- Parametrised successor to the single-target detect path in the camera pipeline.
- Classifies each RGB565 pixel against a per-frame colour window and emits a mode-selected output pixel stream with fixed latency.
- Accumulates the centroid of matched pixels, resolves it with an iterative divider at frame end, and publishes x/y centre-of-mass plus a size class.
- Sits between the camera/frame-buffer stream and the display overlay and gesture logic.

---
 rtl/blob_pkg.sv | 26 ++
 rtl/seq_divider.sv | 67 ++++++
 rtl/blob_track_filter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_blob_track_filter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// Shared types and encodings for the blob tracking filter.
package blob_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DIV_X,
    DIV_Y,
    PUBLISH
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam logic [1:0] MODE_PASS    = 2'd0;
  localparam logic [1:0] MODE_MASK    = 2'd1;
  localparam logic [1:0] MODE_OVERLAY = 2'd2;
  localparam logic [1:0] MODE_CROSS   = 2'd3;

  localparam logic [1:0] REC_NONE  = 2'd0;
  localparam logic [1:0] REC_SMALL = 2'd1;
  localparam logic [1:0] REC_LARGE = 2'd2;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses NUM_W+1 cycles after start.
module seq_divider #(
  parameter int NUM_W = 32,
  parameter int DEN_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quo
);
  localparam int CW = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [NUM_W-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DEN_W:0]   w_shift;
  logic             w_ge;
  logic [DEN_W-1:0] w_rem_next;

  // Numerator bits shift out of r_q's MSB while quotient bits shift in at the LSB.
  always_comb begin
    w_shift    = {r_rem, r_q[NUM_W-1]};
    w_ge       = (w_shift >= {1'b0, r_den});
    w_rem_next = w_ge ? DEN_W'(w_shift - {1'b0, r_den}) : w_shift[DEN_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= '0;
        r_den  <= den;
        r_q    <= num;
        r_cnt  <= CW'(NUM_W);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_next;
        r_q   <= {r_q[NUM_W-2:0], w_ge};
        r_cnt <= r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign quo  = r_q;

endmodule

// File: rtl/blob_track_filter.sv
// Colour-window blob tracker: 2-stage pixel pipeline plus per-frame centroid via a shared divider.
module blob_track_filter
  import blob_pkg::*;
#(
  parameter int          H_BITS      = 11,
  parameter int          V_BITS      = 10,
  parameter int          H_LAST      = 1023,
  parameter int          V_LAST      = 767,
  parameter int          MIN_COUNT   = 64,
  parameter int          LARGE_COUNT = 4096,
  parameter logic [15:0] HIGHLIGHT   = 16'hF800
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              data_valid_in,
  input  logic [15:0]       pixel_data_in,
  input  logic [H_BITS-1:0] hcount_in,
  input  logic [V_BITS-1:0] vcount_in,
  input  logic [15:0]       thr_lo_in,
  input  logic [15:0]       thr_hi_in,
  input  logic [1:0]        mode_in,
  output logic              data_valid_out,
  output logic [15:0]       pixel_data_out,
  output logic [H_BITS-1:0] hcount_out,
  output logic [V_BITS-1:0] vcount_out,
  output logic [H_BITS-1:0] x_com,
  output logic [V_BITS-1:0] y_com,
  output logic [1:0]        recognized,
  output logic              com_valid_out,
  output logic              frame_drop_out
);
  localparam int CNT_W = H_BITS + V_BITS;
  localparam int SX_W  = 2 * H_BITS + V_BITS;
  localparam int SY_W  = H_BITS + 2 * V_BITS;
  localparam int DIV_W = (SX_W > SY_W) ? SX_W : SY_W;

  localparam logic [H_BITS-1:0] H_END   = H_BITS'(H_LAST);
  localparam logic [V_BITS-1:0] V_END   = V_BITS'(V_LAST);
  localparam logic [CNT_W-1:0]  MIN_C   = CNT_W'(MIN_COUNT);
  localparam logic [CNT_W-1:0]  LARGE_C = CNT_W'(LARGE_COUNT);

  state_t r_state, w_state_next;

  logic [15:0] r_thr_lo, r_thr_hi;
  logic [1:0]  r_mode;
  logic [15:0] w_lo_eff, w_hi_eff;
  logic [1:0]  w_mode_eff;
  rgb565_t     w_pix, w_lo, w_hi;
  logic        w_start, w_end, w_match, w_hit;

  logic              r_s1_valid, r_s1_match;
  logic [15:0]       r_s1_pix;
  logic [H_BITS-1:0] r_s1_h;
  logic [V_BITS-1:0] r_s1_v;
  logic [1:0]        r_s1_mode;
  logic [15:0]       w_out_pix;

  logic              r_s2_valid;
  logic [15:0]       r_s2_pix;
  logic [H_BITS-1:0] r_s2_h;
  logic [V_BITS-1:0] r_s2_v;

  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [SX_W-1:0]  r_sx, w_sx_next;
  logic [SY_W-1:0]  r_sy, w_sy_next;
  logic [CNT_W-1:0] r_snap_cnt;
  logic [SY_W-1:0]  r_snap_sy;

  logic             w_div_start, w_div_done, w_div_busy_unused;
  logic [DIV_W-1:0] w_div_num, w_div_quo;
  logic [CNT_W-1:0] w_div_den;
  logic [DIV_W-H_BITS-1:0] w_quo_hi_unused;

  logic [H_BITS-1:0] r_qx, r_x;
  logic [V_BITS-1:0] r_qy, r_y;
  logic [1:0]        r_rec;
  logic              r_com_valid, r_drop;
  logic              w_pub, w_pub_none, w_drop;

  // The frame-start pixel is classified with the thresholds/mode presented alongside it.
  assign w_start    = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign w_end      = data_valid_in && (hcount_in == H_END) && (vcount_in == V_END);
  assign w_lo_eff   = w_start ? thr_lo_in : r_thr_lo;
  assign w_hi_eff   = w_start ? thr_hi_in : r_thr_hi;
  assign w_mode_eff = w_start ? mode_in : r_mode;
  assign w_pix      = rgb565_t'(pixel_data_in);
  assign w_lo       = rgb565_t'(w_lo_eff);
  assign w_hi       = rgb565_t'(w_hi_eff);
  assign w_match    = (w_pix.r >= w_lo.r) && (w_pix.r <= w_hi.r) &&
                      (w_pix.g >= w_lo.g) && (w_pix.g <= w_hi.g) &&
                      (w_pix.b >= w_lo.b) && (w_pix.b <= w_hi.b);
  assign w_hit      = data_valid_in && w_match;

  always_comb begin
    w_cnt_next = (w_start ? '0 : r_cnt) + CNT_W'(w_hit);
    w_sx_next  = (w_start ? '0 : r_sx) + (w_hit ? SX_W'(hcount_in) : '0);
    w_sy_next  = (w_start ? '0 : r_sy) + (w_hit ? SY_W'(vcount_in) : '0);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_thr_lo   <= '0;
      r_thr_hi   <= '0;
      r_mode     <= '0;
      r_cnt      <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_snap_cnt <= '0;
      r_snap_sy  <= '0;
    end else if (data_valid_in) begin
      r_cnt <= w_cnt_next;
      r_sx  <= w_sx_next;
      r_sy  <= w_sy_next;
      if (w_start) begin
        r_thr_lo <= thr_lo_in;
        r_thr_hi <= thr_hi_in;
        r_mode   <= mode_in;
      end
      if (w_end && (r_state == ACCUM)) begin
        r_snap_cnt <= w_cnt_next;
        r_snap_sy  <= w_sy_next;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_h     <= '0;
      r_s1_v     <= '0;
      r_s1_mode  <= '0;
    end else begin
      r_s1_valid <= data_valid_in;
      if (data_valid_in) begin
        r_s1_match <= w_match;
        r_s1_pix   <= pixel_data_in;
        r_s1_h     <= hcount_in;
        r_s1_v     <= vcount_in;
        r_s1_mode  <= w_mode_eff;
      end
    end
  end

  always_comb begin
    w_out_pix = r_s1_pix;
    case (r_s1_mode)
      MODE_PASS:    w_out_pix = r_s1_pix;
      MODE_MASK:    w_out_pix = r_s1_match ? 16'hFFFF : 16'h0000;
      MODE_OVERLAY: w_out_pix = r_s1_match ? HIGHLIGHT : r_s1_pix;
      MODE_CROSS:   w_out_pix = ((r_s1_h == r_x) || (r_s1_v == r_y)) ? 16'hFFFF : r_s1_pix;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_s2_valid <= 1'b0;
      r_s2_pix   <= '0;
      r_s2_h     <= '0;
      r_s2_v     <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_pix <= w_out_pix;
        r_s2_h   <= r_s1_h;
        r_s2_v   <= r_s1_v;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= ACCUM;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM:   if (w_end && (w_cnt_next >= MIN_C)) w_state_next = DIV_X;
      DIV_X:   if (w_div_done) w_state_next = DIV_Y;
      DIV_Y:   if (w_div_done) w_state_next = PUBLISH;
      PUBLISH: w_state_next = ACCUM;
      default: w_state_next = ACCUM;
    endcase
  end

  // x division is launched straight from the frame-end pixel's sums; y uses the snapshot.
  always_comb begin
    w_div_start = 1'b0;
    w_div_num   = '0;
    w_div_den   = '0;
    w_pub       = 1'b0;
    w_pub_none  = 1'b0;
    w_drop      = w_end && (r_state != ACCUM);
    case (r_state)
      ACCUM: begin
        if (w_end) begin
          if (w_cnt_next >= MIN_C) begin
            w_div_start = 1'b1;
            w_div_num   = DIV_W'(w_sx_next);
            w_div_den   = w_cnt_next;
          end else begin
            w_pub_none = 1'b1;
          end
        end
      end
      DIV_X: begin
        if (w_div_done) begin
          w_div_start = 1'b1;
          w_div_num   = DIV_W'(r_snap_sy);
          w_div_den   = r_snap_cnt;
        end
      end
      PUBLISH: w_pub = 1'b1;
      default: ;
    endcase
  end

  seq_divider #(
    .NUM_W(DIV_W),
    .DEN_W(CNT_W)
  ) u_div (
    .clk  (clk_in),
    .rst  (rst_in),
    .start(w_div_start),
    .num  (w_div_num),
    .den  (w_div_den),
    .busy (w_div_busy_unused),
    .done (w_div_done),
    .quo  (w_div_quo)
  );

  assign w_quo_hi_unused = w_div_quo[DIV_W-1:H_BITS];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_qx        <= '0;
      r_qy        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_rec       <= REC_NONE;
      r_com_valid <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      if ((r_state == DIV_X) && w_div_done) r_qx <= w_div_quo[H_BITS-1:0];
      if ((r_state == DIV_Y) && w_div_done) r_qy <= w_div_quo[V_BITS-1:0];
      r_com_valid <= w_pub || w_pub_none;
      r_drop      <= w_drop;
      if (w_pub) begin
        r_x   <= r_qx;
        r_y   <= r_qy;
        r_rec <= (r_snap_cnt >= LARGE_C) ? REC_LARGE : REC_SMALL;
      end else if (w_pub_none) begin
        r_rec <= REC_NONE;
      end
    end
  end

  assign data_valid_out = r_s2_valid;
  assign pixel_data_out = r_s2_pix;
  assign hcount_out     = r_s2_h;
  assign vcount_out     = r_s2_v;
  assign x_com          = r_x;
  assign y_com          = r_y;
  assign recognized     = r_rec;
  assign com_valid_out  = r_com_valid;
  assign frame_drop_out = r_drop;

endmodule

// File: tb/tb_blob_track_filter.sv
// Directed bench for blob_track_filter: pixel pipeline model plus hand-computed centroid results.
module tb_blob_track_filter;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        data_valid_in = 1'b0;
  logic [15:0] pixel_data_in = '0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [15:0] thr_lo_in = 16'h8000;
  logic [15:0] thr_hi_in = 16'hFFFF;
  logic [1:0]  mode_in = 2'd0;
  logic        data_valid_out;
  logic [15:0] pixel_data_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [10:0] x_com;
  logic [9:0]  y_com;
  logic [1:0]  recognized;
  logic        com_valid_out;
  logic        frame_drop_out;

  blob_track_filter #(
    .H_BITS(11), .V_BITS(10), .H_LAST(1023), .V_LAST(767),
    .MIN_COUNT(64), .LARGE_COUNT(4096), .HIGHLIGHT(16'hF800)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
    .pixel_data_in(pixel_data_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .thr_lo_in(thr_lo_in), .thr_hi_in(thr_hi_in), .mode_in(mode_in),
    .data_valid_out(data_valid_out), .pixel_data_out(pixel_data_out),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .x_com(x_com), .y_com(y_com), .recognized(recognized),
    .com_valid_out(com_valid_out), .frame_drop_out(frame_drop_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: thresholds/mode latched at frame start, expected published centroid.
  logic [15:0] s_lo = '0, s_hi = '0;
  logic [1:0]  s_mode = '0;
  logic [10:0] ex_x = '0;
  logic [9:0]  ex_y = '0;
  logic        d1_v = 1'b0, d2_v = 1'b0;
  logic [15:0] d1_p = '0, d2_p = '0, hd_p = '0;
  logic [10:0] d1_h = '0, d2_h = '0, hd_h = '0;
  logic [9:0]  d1_y = '0, d2_y = '0, hd_y = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic in_win(input logic [15:0] p, input logic [15:0] lo, input logic [15:0] hi);
    return (p[15:11] >= lo[15:11]) && (p[15:11] <= hi[15:11]) &&
           (p[10:5]  >= lo[10:5])  && (p[10:5]  <= hi[10:5])  &&
           (p[4:0]   >= lo[4:0])   && (p[4:0]   <= hi[4:0]);
  endfunction

  task automatic step(input logic v, input logic [15:0] p, input logic [10:0] h, input logic [9:0] y);
    logic [15:0] ep;
    logic m;
    @(posedge clk_in); #1;
    chk("dv_out",   32'(data_valid_out), 32'(d2_v));
    chk("pix_out",  32'(pixel_data_out), 32'(d2_p));
    chk("hcnt_out", 32'(hcount_out),     32'(d2_h));
    chk("vcnt_out", 32'(vcount_out),     32'(d2_y));
    d2_v = d1_v; d2_p = d1_p; d2_h = d1_h; d2_y = d1_y;
    if (v) begin
      if (h == 11'd0 && y == 10'd0) begin
        s_lo = thr_lo_in; s_hi = thr_hi_in; s_mode = mode_in;
      end
      m = in_win(p, s_lo, s_hi);
      case (s_mode)
        2'd0:    ep = p;
        2'd1:    ep = m ? 16'hFFFF : 16'h0000;
        2'd2:    ep = m ? 16'hF800 : p;
        default: ep = (h == ex_x || y == ex_y) ? 16'hFFFF : p;
      endcase
      hd_p = ep; hd_h = h; hd_y = y;
    end
    d1_v = v; d1_p = hd_p; d1_h = hd_h; d1_y = hd_y;
    data_valid_in = v; pixel_data_in = p; hcount_in = h; vcount_in = y;
  endtask

  // Idle cycles carry frame-start coordinates and a matching colour that must be ignored.
  task automatic idle();
    step(1'b0, 16'hF800, 11'd0, 10'd0);
  endtask

  task automatic square(input int x0, input int y0, input int n, input logic [15:0] p);
    for (int y = y0; y < y0 + n; y++) begin
      for (int x = x0; x < x0 + n; x++) begin
        if ((x + y) % 7 == 3) idle();
        step(1'b1, p, 11'(x), 10'(y));
      end
    end
  endtask

  task automatic wait_com(input logic [10:0] x, input logic [9:0] y, input logic [1:0] r);
    int k = 0;
    while (com_valid_out !== 1'b1 && k < 200) begin
      idle();
      k++;
    end
    chk("com_valid", 32'(com_valid_out), 32'd1);
    chk("x_com",     32'(x_com),         32'(x));
    chk("y_com",     32'(y_com),         32'(y));
    chk("recog",     32'(recognized),    32'(r));
    ex_x = x; ex_y = y;
    idle();
    chk("com_pulse", 32'(com_valid_out), 32'd0);
  endtask

  task automatic frame_end();
    step(1'b1, 16'h0000, 11'd1023, 10'd767);
  endtask

  initial begin
    repeat (2) idle();
    chk("rst_x",    32'(x_com),          32'd0);
    chk("rst_y",    32'(y_com),          32'd0);
    chk("rst_rec",  32'(recognized),     32'd0);
    chk("rst_cv",   32'(com_valid_out),  32'd0);
    chk("rst_drop", 32'(frame_drop_out), 32'd0);
    @(negedge clk_in) rst_in = 1'b0;

    // Pass-through with random pixels and gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      else step(1'b1, 16'($urandom), 11'($urandom_range(1, 1000)), 10'($urandom_range(1, 700)));
    end

    // 20x20 red square: centroid (109,209), small
    thr_lo_in = 16'h8000; thr_hi_in = 16'hFFFF; mode_in = 2'd0;
    step(1'b1, 16'h0000, 11'd0, 10'd0);
    square(100, 200, 20, 16'hF800);
    frame_end();
    wait_com(11'd109, 10'd209, 2'd1);

    // Mask mode, 10 matches, thresholds/mode changed mid-frame
    mode_in = 2'd1;
    step(1'b1, 16'h0000, 11'd0, 10'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 16'hF800, 11'(300 + i), 10'd300);
    thr_lo_in = 16'h0000; mode_in = 2'd2;
    for (int i = 0; i < 20; i++) step(1'b1, 16'h0000, 11'(400 + i), 10'd400);
    frame_end();
    wait_com(11'd109, 10'd209, 2'd0);

    // New thresholds and mode apply from this frame's (0,0)
    step(1'b1, 16'h0000, 11'd0, 10'd0);
    frame_end();
    wait_com(11'd109, 10'd209, 2'd0);

    // 80x80 at origin, overlay mode: centroid (39,39), large
    thr_lo_in = 16'h8000; mode_in = 2'd2;
    square(0, 0, 80, 16'hF800);
    step(1'b1, 16'h1234, 11'd500, 10'd500);
    frame_end();
    wait_com(11'd39, 10'd39, 2'd2);

    // Crosshair on the published (39,39)
    mode_in = 2'd3;
    step(1'b1, 16'h0841, 11'd0, 10'd0);
    step(1'b1, 16'h1234, 11'd39, 10'd5);
    step(1'b1, 16'h1234, 11'd5, 10'd39);
    step(1'b1, 16'h1234, 11'd6, 10'd6);
    frame_end();
    wait_com(11'd39, 10'd39, 2'd0);

    // Frame end while dividing is dropped; in-flight result still published
    mode_in = 2'd0;
    step(1'b1, 16'h0000, 11'd0, 10'd0);
    square(100, 200, 20, 16'hF800);
    frame_end();
    step(1'b1, 16'h0000, 11'd0, 10'd0);
    frame_end();
    idle();
    chk("drop_pulse", 32'(frame_drop_out), 32'd1);
    idle();
    chk("drop_clear", 32'(frame_drop_out), 32'd0);
    wait_com(11'd109, 10'd209, 2'd1);

    // Asynchronous reset during DIV_Y
    step(1'b1, 16'h0000, 11'd0, 10'd0);
    square(100, 200, 20, 16'hF800);
    frame_end();
    repeat (50) idle();
    #2 rst_in = 1'b1;
    #1;
    chk("arst_x",    32'(x_com),          32'd0);
    chk("arst_y",    32'(y_com),          32'd0);
    chk("arst_rec",  32'(recognized),     32'd0);
    chk("arst_cv",   32'(com_valid_out),  32'd0);
    chk("arst_drop", 32'(frame_drop_out), 32'd0);
    chk("arst_dv",   32'(data_valid_out), 32'd0);
    chk("arst_pix",  32'(pixel_data_out), 32'd0);
    chk("arst_h",    32'(hcount_out),     32'd0);
    chk("arst_v",    32'(vcount_out),     32'd0);
    d1_v = 1'b0; d2_v = 1'b0; d1_p = '0; d2_p = '0; hd_p = '0;
    d1_h = '0; d2_h = '0; hd_h = '0; d1_y = '0; d2_y = '0; hd_y = '0;
    s_lo = '0; s_hi = '0; s_mode = '0; ex_x = '0; ex_y = '0;
    repeat (2) idle();
    @(negedge clk_in) rst_in = 1'b0;

    step(1'b1, 16'h0000, 11'd0, 10'd0);
    square(100, 200, 20, 16'hF800);
    frame_end();
    wait_com(11'd109, 10'd209, 2'd1);

    repeat (3) idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
